// File: rtl/ex_mem_stage_reg_pkg.sv
// ex_mem_stage_reg_pkg
//   Shared definitions for the EX/MEM pipeline boundary: opcode encodings,
//   ex_ctl bit positions, write-back select encodings and FSM state codes.
package ex_mem_stage_reg_pkg;

  localparam logic [4:0] HALT_OPC_DEF = 5'b00000;

  // Control-transfer opcodes (instr[15:11]); these are the instructions
  // that raise ex_pc_write in EX.
  localparam logic [4:0] OPC_J    = 5'b00100;
  localparam logic [4:0] OPC_JR   = 5'b00101;
  localparam logic [4:0] OPC_JAL  = 5'b00110;
  localparam logic [4:0] OPC_JALR = 5'b00111;
  localparam logic [4:0] OPC_BEQZ = 5'b01100;
  localparam logic [4:0] OPC_BNEZ = 5'b01101;
  localparam logic [4:0] OPC_BLTZ = 5'b01110;
  localparam logic [4:0] OPC_BGEZ = 5'b01111;

  // ex_ctl = {reg_write, mem_read, mem_write, wb_sel[1:0], halt_ok}
  localparam int CTL_W         = 6;
  localparam int CTL_REG_WRITE = 5;
  localparam int CTL_MEM_READ  = 4;
  localparam int CTL_MEM_WRITE = 3;
  localparam int CTL_WB_SEL_HI = 2;
  localparam int CTL_WB_SEL_LO = 1;
  localparam int CTL_HALT_OK   = 0;

  typedef enum logic [1:0] {
    WB_ALU    = 2'b00,
    WB_MEM    = 2'b01,
    WB_PC_INC = 2'b10,
    WB_SLBI   = 2'b11
  } wb_sel_e;

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_REDIR  = 2'b01,
    ST_HALTED = 2'b10
  } exmem_state_e;

  function automatic logic is_xfer_opc(input logic [4:0] opc);
    return opc inside {OPC_J, OPC_JR, OPC_JAL, OPC_JALR,
                       OPC_BEQZ, OPC_BNEZ, OPC_BLTZ, OPC_BGEZ};
  endfunction

endpackage

// File: rtl/ex_mem_stage_reg_pipe_field_reg.sv
// pipe_field_reg
//   One W-bit pipeline field: loads d when en is high, synchronous clear
//   (dominates en).
//   Ports: clk, rst (sync, active high), en, d[W-1:0], q[W-1:0]
module pipe_field_reg #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst)     q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/ex_mem_stage_reg.sv
// ex_mem_stage_reg
//   EX/MEM pipeline register. Captures execute results into MEM, issues a
//   one-cycle redirect/flush for taken branches and jumps, and tracks HALT.
//   Ports:
//     clk, rst (sync, active high)
//     ex_*      execute-stage results and control, ex_valid qualifies them
//     mem_stall back-pressure from MEM
//     mem_*     registered copies (mem_ctl forced 0 when mem_valid is 0)
//     ex_hold   back-pressure to ID/EX
//     redirect, redirect_pc, flush_younger   control-transfer redirect
//     halted    sticky until rst
//   Optional: define EXMEM_PERF_EN to add perf_redirects / perf_bubbles
//   saturating counters.
//
//   state  | meaning
//   RUN    | normal capture
//   REDIR  | redirect/flush pulse this cycle; EX slot is wrong-path
//   HALTED | HALT reached MEM; no further capture
module ex_mem_stage_reg
  import ex_mem_stage_reg_pkg::*;
#(
  parameter int         DATA_W   = 16,
  parameter int         REG_AW   = 3,
  parameter logic [4:0] HALT_OPC = HALT_OPC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic [15:0]       ex_instr,
  input  logic [DATA_W-1:0] ex_pc_inc,
  input  logic [DATA_W-1:0] ex_alu_out,
  input  logic [DATA_W-1:0] ex_slbi_out,
  input  logic [DATA_W-1:0] ex_pc_next,
  input  logic              ex_pc_write,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic [REG_AW-1:0] ex_wr_reg,
  input  logic [CTL_W-1:0]  ex_ctl,
  input  logic              mem_stall,
  output logic              mem_valid,
  output logic [15:0]       mem_instr,
  output logic [DATA_W-1:0] mem_pc_inc,
  output logic [DATA_W-1:0] mem_alu_out,
  output logic [DATA_W-1:0] mem_slbi_out,
  output logic [DATA_W-1:0] mem_store_data,
  output logic [REG_AW-1:0] mem_wr_reg,
  output logic [CTL_W-1:0]  mem_ctl,
  output logic              ex_hold,
  output logic              redirect,
  output logic [DATA_W-1:0] redirect_pc,
  output logic              flush_younger,
`ifdef EXMEM_PERF_EN
  output logic [15:0]       perf_redirects,
  output logic [15:0]       perf_bubbles,
`endif
  output logic              halted
);

  exmem_state_e     state;
  logic             redirect_q;
  logic             accept;
  logic             cap_valid;
  logic             take_xfer;
  logic             take_halt;
  logic [CTL_W-1:0] ctl_q;

  assign halted        = (state == ST_HALTED);
  assign redirect      = redirect_q;
  assign flush_younger = redirect_q;
  assign ex_hold       = mem_stall | halted;
  assign accept        = ~mem_stall & ~halted;
  // The EX slot during a redirect cycle is wrong-path: captured as a bubble.
  assign cap_valid     = ex_valid & ~redirect_q;
  assign take_xfer     = cap_valid & ex_pc_write & (ex_pc_next != ex_pc_inc);
  assign take_halt     = cap_valid & (ex_instr[15:11] == HALT_OPC);
  assign mem_ctl       = mem_valid ? ctl_q : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_RUN;
      redirect_q  <= 1'b0;
      redirect_pc <= '0;
      mem_valid   <= 1'b0;
    end else begin
      redirect_q <= 1'b0;
      case (state)
        ST_RUN, ST_REDIR: begin
          // REDIR lasts exactly one cycle even when MEM stalls.
          state <= ST_RUN;
          if (accept) begin
            mem_valid <= cap_valid;
            if (take_xfer) begin
              state       <= ST_REDIR;
              redirect_q  <= 1'b1;
              redirect_pc <= ex_pc_next;
            end else if (take_halt) begin
              state <= ST_HALTED;
            end
          end
        end
        ST_HALTED: begin
          state     <= ST_HALTED;
          mem_valid <= 1'b0;
        end
        default: state <= ST_RUN;
      endcase
    end
  end

  pipe_field_reg #(.W(16))     u_instr (.clk(clk), .rst(rst), .en(accept), .d(ex_instr),      .q(mem_instr));
  pipe_field_reg #(.W(DATA_W)) u_pcinc (.clk(clk), .rst(rst), .en(accept), .d(ex_pc_inc),     .q(mem_pc_inc));
  pipe_field_reg #(.W(DATA_W)) u_alu   (.clk(clk), .rst(rst), .en(accept), .d(ex_alu_out),    .q(mem_alu_out));
  pipe_field_reg #(.W(DATA_W)) u_slbi  (.clk(clk), .rst(rst), .en(accept), .d(ex_slbi_out),   .q(mem_slbi_out));
  pipe_field_reg #(.W(DATA_W)) u_store (.clk(clk), .rst(rst), .en(accept), .d(ex_store_data), .q(mem_store_data));
  pipe_field_reg #(.W(REG_AW)) u_wrreg (.clk(clk), .rst(rst), .en(accept), .d(ex_wr_reg),     .q(mem_wr_reg));
  pipe_field_reg #(.W(CTL_W))  u_ctl   (.clk(clk), .rst(rst), .en(accept), .d(ex_ctl),        .q(ctl_q));

`ifdef EXMEM_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_redirects <= '0;
      perf_bubbles   <= '0;
    end else begin
      if (accept && take_xfer && perf_redirects != 16'hFFFF)
        perf_redirects <= perf_redirects + 16'd1;
      if (accept && !cap_valid && perf_bubbles != 16'hFFFF)
        perf_bubbles <= perf_bubbles + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ex_mem_stage_reg.sv
module tb_ex_mem_stage_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic [15:0] ex_instr, ex_pc_inc, ex_alu_out, ex_slbi_out, ex_pc_next, ex_store_data;
  logic        ex_pc_write;
  logic [2:0]  ex_wr_reg;
  logic [5:0]  ex_ctl;
  logic        mem_stall;
  logic        mem_valid;
  logic [15:0] mem_instr, mem_pc_inc, mem_alu_out, mem_slbi_out, mem_store_data;
  logic [2:0]  mem_wr_reg;
  logic [5:0]  mem_ctl;
  logic        ex_hold, redirect, flush_younger, halted;
  logic [15:0] redirect_pc;
`ifdef EXMEM_PERF_EN
  logic [15:0] perf_redirects, perf_bubbles;
`endif

  always #5 clk = ~clk;

  ex_mem_stage_reg dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_instr(ex_instr), .ex_pc_inc(ex_pc_inc),
    .ex_alu_out(ex_alu_out), .ex_slbi_out(ex_slbi_out), .ex_pc_next(ex_pc_next),
    .ex_pc_write(ex_pc_write), .ex_store_data(ex_store_data), .ex_wr_reg(ex_wr_reg),
    .ex_ctl(ex_ctl), .mem_stall(mem_stall),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_pc_inc(mem_pc_inc),
    .mem_alu_out(mem_alu_out), .mem_slbi_out(mem_slbi_out),
    .mem_store_data(mem_store_data), .mem_wr_reg(mem_wr_reg), .mem_ctl(mem_ctl),
    .ex_hold(ex_hold), .redirect(redirect), .redirect_pc(redirect_pc),
    .flush_younger(flush_younger),
`ifdef EXMEM_PERF_EN
    .perf_redirects(perf_redirects), .perf_bubbles(perf_bubbles),
`endif
    .halted(halted)
  );

  // What the MEM side should show after a clock edge.
  typedef struct {
    logic        valid;
    logic [15:0] instr, pc_inc, alu, slbi, store;
    logic [2:0]  wr_reg;
    logic [5:0]  ctl;
    logic        hold, redir;
    logic [15:0] rpc;
    logic        halted;
  } exp_t;

  exp_t sb_q[$];
  exp_t md;
  int   checks = 0;
  int   errors = 0;

  task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t zero_exp();
    exp_t z;
    z.valid = 0; z.instr = 0; z.pc_inc = 0; z.alu = 0; z.slbi = 0; z.store = 0;
    z.wr_reg = 0; z.ctl = 0; z.hold = 0; z.redir = 0; z.rpc = 0; z.halted = 0;
    return z;
  endfunction

  // Reference behaviour: the MEM slot receives whatever EX offers unless MEM
  // stalls or the pipe is halted; a redirect lasts one cycle and turns the
  // next EX instruction into a bubble; a retired HALT freezes everything.
  task automatic model_step();
    exp_t n;
    exp_t e;
    logic real_instr;
    n = md;
    if (rst) begin
      n = zero_exp();
    end else begin
      n.redir = 0;
      if (md.halted) begin
        n.valid = 0;
      end else if (!mem_stall) begin
        real_instr = ex_valid && !md.redir;
        n.valid  = real_instr;
        n.instr  = ex_instr;  n.pc_inc = ex_pc_inc; n.alu = ex_alu_out;
        n.slbi   = ex_slbi_out; n.store = ex_store_data;
        n.wr_reg = ex_wr_reg; n.ctl = ex_ctl;
        if (real_instr && ex_pc_write && ex_pc_next != ex_pc_inc) begin
          n.redir = 1;
          n.rpc   = ex_pc_next;
        end else if (real_instr && ex_instr[15:11] == 5'b00000) begin
          n.halted = 1;
        end
      end
    end
    n.hold = mem_stall | n.halted;
    md = n;
    e = n;
    if (!e.valid) e.ctl = 0;
    sb_q.push_back(e);
  endtask

  // Inputs are set by the caller after a falling edge; this records the
  // expectation for the coming rising edge and moves to the next falling edge.
  task automatic step();
    model_step();
    @(negedge clk);
  endtask

  task automatic rand_in();
    ex_valid      = ($urandom % 5) != 0;
    ex_instr      = 16'($urandom);
    if (ex_instr[15:11] == 5'b00000 && $urandom_range(0, 3) != 0) ex_instr[15:11] = 5'b01000;
    ex_pc_inc     = 16'($urandom);
    ex_pc_write   = ($urandom % 3) == 0;
    ex_pc_next    = ($urandom % 2 == 0) ? ex_pc_inc : 16'($urandom);
    ex_alu_out    = 16'($urandom);
    ex_slbi_out   = 16'($urandom);
    ex_store_data = 16'($urandom);
    ex_wr_reg     = 3'($urandom);
    ex_ctl        = 6'($urandom);
    mem_stall     = ($urandom % 4) == 0;
  endtask

  task automatic plain(input logic [15:0] instr, input logic [15:0] alu);
    rand_in();
    ex_valid = 1; ex_instr = instr; ex_alu_out = alu;
    ex_pc_write = 0; mem_stall = 0; rst = 0;
  endtask

  // Monitor: one sample per cycle, after the rising edge has settled.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        cmp("mem_valid",      {15'd0, mem_valid},     {15'd0, e.valid});
        cmp("mem_instr",      mem_instr,              e.instr);
        cmp("mem_pc_inc",     mem_pc_inc,             e.pc_inc);
        cmp("mem_alu_out",    mem_alu_out,            e.alu);
        cmp("mem_slbi_out",   mem_slbi_out,           e.slbi);
        cmp("mem_store_data", mem_store_data,         e.store);
        cmp("mem_wr_reg",     {13'd0, mem_wr_reg},    {13'd0, e.wr_reg});
        cmp("mem_ctl",        {10'd0, mem_ctl},       {10'd0, e.ctl});
        cmp("ex_hold",        {15'd0, ex_hold},       {15'd0, e.hold});
        cmp("redirect",       {15'd0, redirect},      {15'd0, e.redir});
        cmp("flush_younger",  {15'd0, flush_younger}, {15'd0, e.redir});
        cmp("redirect_pc",    redirect_pc,            e.rpc);
        cmp("halted",         {15'd0, halted},        {15'd0, e.halted});
      end
    end
  end

  initial begin
    md = zero_exp();
    rst = 1;
    rand_in();
    @(negedge clk);

    // reset for two cycles with random inputs
    rst = 1; rand_in(); step();
    rst = 1; rand_in(); step();

    // plain ADD
    plain(16'hD800, 16'h1234); step();

    // taken BEQZ, then a wrong-path instruction, then normal flow
    plain(16'h6000, 16'h0001);
    ex_pc_write = 1; ex_pc_inc = 16'h0010; ex_pc_next = 16'h0030; step();
    plain(16'h4123, 16'h5555); step();
    plain(16'h4124, 16'h6666); step();

    // not-taken branch
    plain(16'h6800, 16'h0002);
    ex_pc_write = 1; ex_pc_inc = 16'h0012; ex_pc_next = 16'h0012; step();

    // three stalled cycles with changing inputs, then release
    for (int i = 0; i < 3; i++) begin
      rand_in(); rst = 0; mem_stall = 1; step();
    end
    plain(16'hD900, 16'hBEEF); step();

    // taken jump followed by a stall during the redirect cycle
    plain(16'h2000, 16'h0003);
    ex_pc_write = 1; ex_pc_inc = 16'h0100; ex_pc_next = 16'h0200; step();
    rand_in(); rst = 0; mem_stall = 1; step();
    plain(16'h4444, 16'h7777); step();

    // HALT, sticky for a few cycles, then reset clears it
    plain(16'h0000, 16'h0BAD); step();
    for (int i = 0; i < 3; i++) begin
      rand_in(); rst = 0; step();
    end
    rand_in(); rst = 1; step();
    plain(16'hD800, 16'hCAFE); step();

    // randomized traffic with occasional resets
    for (int i = 0; i < 800; i++) begin
      rand_in();
      rst = ($urandom % 50) == 0;
      step();
    end

    rst = 0; mem_stall = 0; ex_valid = 0;
    @(posedge clk);
    #2;
    cmp("scoreboard_drained", 16'(sb_q.size()), 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
